// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared types and constants for the pipeline hazard control
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_HALT     = 2'd3
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_write;
      logic idex_bubble;
      logic exmem_write;
      logic memwb_bubble;
   } stage_ctrl_t;

   localparam stage_ctrl_t C_CTRL_IDLE     = 7'b000_0000;
   localparam stage_ctrl_t C_CTRL_RUN      = 7'b110_1010;
   localparam stage_ctrl_t C_CTRL_MEM      = 7'b000_0001;
   localparam stage_ctrl_t C_CTRL_BRANCH   = 7'b111_1110;
   localparam stage_ctrl_t C_CTRL_JUMP     = 7'b111_1010;
   localparam stage_ctrl_t C_CTRL_LOAD_USE = 7'b000_1110;

   localparam logic [5:0] C_OP_RTYPE = 6'h00;
   localparam logic [5:0] C_OP_J     = 6'h02;
   localparam logic [5:0] C_OP_BEQ   = 6'h04;
   localparam logic [5:0] C_OP_LW    = 6'h23;
   localparam logic [5:0] C_OP_SW    = 6'h2b;

   // Decoder helper that produces ifid_uses_rt_i from the ID opcode.
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == C_OP_RTYPE) || (op == C_OP_BEQ) || (op == C_OP_SW);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// ============================================================================
// load_use_detect : flags an ID instruction that reads the register a load in EX writes
// Rev 1.0
// ============================================================================
`default_nettype none

module load_use_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  idex_memread_i,
   input  logic [REG_ADDR_W-1:0] idex_rt_i,
   input  logic [REG_ADDR_W-1:0] ifid_rs_i,
   input  logic [REG_ADDR_W-1:0] ifid_rt_i,
   input  logic                  ifid_uses_rt_i,
   output logic                  hazard_o
);

   logic rs_hit_w;
   logic rt_hit_w;

   assign rs_hit_w = (idex_rt_i == ifid_rs_i);
   assign rt_hit_w = ifid_uses_rt_i && (idex_rt_i == ifid_rt_i);

   // $zero is never a real dependency.
   assign hazard_o = idex_memread_i && (idex_rt_i != '0) && (rs_hit_w || rt_hit_w);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall/flush sequencer for the 5-stage MIPS pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  idex_memread_i,
   input  logic [REG_ADDR_W-1:0] idex_rt_i,
   input  logic [REG_ADDR_W-1:0] ifid_rs_i,
   input  logic [REG_ADDR_W-1:0] ifid_rt_i,
   input  logic                  ifid_uses_rt_i,
   input  logic                  id_jump_i,
   input  logic                  ex_branch_taken_i,
   input  logic                  exmem_memacc_i,
   input  logic                  dmem_ack_i,
   output logic                  dmem_req_o,
   output logic                  pc_write_o,
   output logic                  ifid_write_o,
   output logic                  ifid_flush_o,
   output logic                  idex_write_o,
   output logic                  idex_bubble_o,
   output logic                  exmem_write_o,
   output logic                  memwb_bubble_o,
   output logic                  running_o,
   output logic                  err_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   localparam int              TO_W      = $clog2(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   stage_ctrl_t       run_ctrl_w;
   stage_ctrl_t       ctrl_w;
   logic              lu_w;
   logic              active_w;

   load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use (
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .ifid_uses_rt_i (ifid_uses_rt_i),
      .hazard_o       (lu_w)
   );

   // Priority: memory stall, branch, load-use, jump (a stalled jump re-presents).
   always_comb begin
      run_ctrl_w = C_CTRL_RUN;
      if (exmem_memacc_i && !dmem_ack_i) begin
         run_ctrl_w = C_CTRL_MEM;
      end else if (ex_branch_taken_i) begin
         run_ctrl_w = C_CTRL_BRANCH;
      end else if (lu_w) begin
         run_ctrl_w = C_CTRL_LOAD_USE;
      end else if (id_jump_i) begin
         run_ctrl_w = C_CTRL_JUMP;
      end
   end

   always_comb begin
      state_d = state_q;
      to_d    = to_q;
      err_d   = err_q;
      ctrl_w  = C_CTRL_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            ctrl_w = run_ctrl_w;
            to_d   = '0;
            if (exmem_memacc_i && !dmem_ack_i) state_d = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (dmem_ack_i) begin
               ctrl_w  = run_ctrl_w;
               to_d    = '0;
               state_d = ST_RUN;
            end else begin
               ctrl_w = C_CTRL_MEM;
               if (to_q == C_TO_LAST) begin
                  state_d = ST_HALT;
                  err_d   = 1'b1;
               end else begin
                  to_d = to_q + TO_W'(1);
               end
            end
         end
         ST_HALT: begin
            ctrl_w = C_CTRL_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign active_w = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

   always_comb begin
      cnt_d = cnt_q;
      if (active_w && !ctrl_w.pc_write && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         to_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dmem_req_o     = active_w && exmem_memacc_i;
   assign pc_write_o     = ctrl_w.pc_write;
   assign ifid_write_o   = ctrl_w.ifid_write;
   assign ifid_flush_o   = ctrl_w.ifid_flush;
   assign idex_write_o   = ctrl_w.idex_write;
   assign idex_bubble_o  = ctrl_w.idex_bubble;
   assign exmem_write_o  = ctrl_w.exmem_write;
   assign memwb_bubble_o = ctrl_w.memwb_bubble;
   assign running_o      = active_w;
   assign err_o          = err_q;
   assign stall_cnt_o    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : scoreboard bench for the pipeline hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   localparam int REG_ADDR_W  = 5;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 32;

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble}
   localparam logic [6:0] E_IDLE = 7'b000_0000;
   localparam logic [6:0] E_RUN  = 7'b110_1010;
   localparam logic [6:0] E_MEM  = 7'b000_0001;
   localparam logic [6:0] E_BR   = 7'b111_1110;
   localparam logic [6:0] E_JMP  = 7'b111_1010;
   localparam logic [6:0] E_LU   = 7'b000_1110;

   typedef struct packed {
      logic       start;
      logic       memread;
      logic [4:0] idex_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       jump;
      logic       br;
      logic       memacc;
      logic       ack;
   } stim_t;

   typedef struct packed {
      logic [6:0]       ctl;
      logic             req;
      logic             run;
      logic             err;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   stim_t            in_s;
   exp_t             sb_q[$];
   int               n_tests = 0;
   int               n_fail  = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   logic             dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o;
   logic             idex_write_o, idex_bubble_o, exmem_write_o, memwb_bubble_o;
   logic             running_o, err_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [6:0]       ctl_obs;

   always #5 clk_i = ~clk_i;

   pipeline_hazard_ctrl #(
      .REG_ADDR_W  (REG_ADDR_W),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .start_i           (in_s.start),
      .idex_memread_i    (in_s.memread),
      .idex_rt_i         (in_s.idex_rt),
      .ifid_rs_i         (in_s.rs),
      .ifid_rt_i         (in_s.rt),
      .ifid_uses_rt_i    (in_s.uses_rt),
      .id_jump_i         (in_s.jump),
      .ex_branch_taken_i (in_s.br),
      .exmem_memacc_i    (in_s.memacc),
      .dmem_ack_i        (in_s.ack),
      .dmem_req_o        (dmem_req_o),
      .pc_write_o        (pc_write_o),
      .ifid_write_o      (ifid_write_o),
      .ifid_flush_o      (ifid_flush_o),
      .idex_write_o      (idex_write_o),
      .idex_bubble_o     (idex_bubble_o),
      .exmem_write_o     (exmem_write_o),
      .memwb_bubble_o    (memwb_bubble_o),
      .running_o         (running_o),
      .err_o             (err_o),
      .stall_cnt_o       (stall_cnt_o)
   );

   assign ctl_obs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                     idex_bubble_o, exmem_write_o, memwb_bubble_o};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [6:0] ctl, input logic req, input logic run, input logic err);
      exp_t e;
      e.ctl = ctl;
      e.req = req;
      e.run = run;
      e.err = err;
      e.cnt = exp_cnt;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      e = sb_q.pop_front();
      chk({tag, "/ctl"}, 64'(ctl_obs),     64'(e.ctl));
      chk({tag, "/req"}, 64'(dmem_req_o),  64'(e.req));
      chk({tag, "/run"}, 64'(running_o),   64'(e.run));
      chk({tag, "/err"}, 64'(err_o),       64'(e.err));
      chk({tag, "/cnt"}, 64'(stall_cnt_o), 64'(e.cnt));
   endtask

   // One clock cycle: expectation queued with the stimulus, compared mid-cycle.
   task automatic cyc(input string tag, input logic [6:0] ctl, input logic req,
                      input logic run, input logic err);
      push_exp(ctl, req, run, err);
      @(negedge clk_i);
      pop_cmp(tag);
      if (run && !ctl[6]) exp_cnt++;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      in_s       = '0;
      in_s.start = 1'b1;
      rst_i      = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      push_exp(E_IDLE, 1'b0, 1'b0, 1'b0);
      pop_cmp("rst_hold");
      rst_i = 1'b1;

      // Start-up: one IDLE cycle then RUN.
      cyc("t1_idle", E_IDLE, 1'b0, 1'b0, 1'b0);
      in_s.start = 1'b0;
      cyc("t1_run",  E_RUN,  1'b0, 1'b1, 1'b0);

      // Load-use on rs, then on rt, and the non-hazard cases.
      in_s.memread = 1'b1; in_s.idex_rt = 5'd2; in_s.rs = 5'd2; in_s.rt = 5'd7;
      in_s.uses_rt = pipe_ctrl_pkg::uses_rt(pipe_ctrl_pkg::C_OP_RTYPE);
      cyc("t2_lu_rs", E_LU, 1'b0, 1'b1, 1'b0);
      in_s.memread = 1'b0;
      cyc("t2_after", E_RUN, 1'b0, 1'b1, 1'b0);
      in_s.memread = 1'b1; in_s.idex_rt = 5'd0; in_s.rs = 5'd0; in_s.rt = 5'd0;
      cyc("t2_rt_zero", E_RUN, 1'b0, 1'b1, 1'b0);
      in_s.idex_rt = 5'd5; in_s.rs = 5'd1; in_s.rt = 5'd5;
      in_s.uses_rt = pipe_ctrl_pkg::uses_rt(pipe_ctrl_pkg::C_OP_LW);
      cyc("t2_rt_unused", E_RUN, 1'b0, 1'b1, 1'b0);
      in_s.uses_rt = pipe_ctrl_pkg::uses_rt(pipe_ctrl_pkg::C_OP_SW);
      cyc("t2_lu_rt", E_LU, 1'b0, 1'b1, 1'b0);

      // Branch over load-use, jump under load-use, plain jump.
      in_s.br = 1'b1;
      cyc("t3_br_lu", E_BR, 1'b0, 1'b1, 1'b0);
      in_s.br = 1'b0; in_s.jump = 1'b1;
      cyc("t3_jmp_lu", E_LU, 1'b0, 1'b1, 1'b0);
      in_s.memread = 1'b0;
      cyc("t3_jmp", E_JMP, 1'b0, 1'b1, 1'b0);
      in_s.jump = 1'b0;

      // Zero-wait access, then an ack three cycles late with a branch on the ack cycle.
      in_s.memacc = 1'b1; in_s.ack = 1'b1;
      cyc("t4_zero_wait", E_RUN, 1'b1, 1'b1, 1'b0);
      in_s.ack = 1'b0;
      cyc("t4_stall", E_MEM, 1'b1, 1'b1, 1'b0);
      cyc("t4_wait1", E_MEM, 1'b1, 1'b1, 1'b0);
      cyc("t4_wait2", E_MEM, 1'b1, 1'b1, 1'b0);
      in_s.ack = 1'b1; in_s.br = 1'b1;
      cyc("t4_ack_br", E_BR, 1'b1, 1'b1, 1'b0);
      in_s.ack = 1'b0; in_s.br = 1'b0; in_s.memacc = 1'b0;
      cyc("t4_resume", E_RUN, 1'b0, 1'b1, 1'b0);
      chk("t4_cnt_total", 64'(stall_cnt_o), 64'd6);

      // Timeout: one stall cycle plus MEM_TIMEOUT wait cycles, then sticky HALT.
      in_s.memacc = 1'b1;
      cyc("t5_stall", E_MEM, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < MEM_TIMEOUT; i++) cyc("t5_wait", E_MEM, 1'b1, 1'b1, 1'b0);
      in_s.start = 1'b1;
      cyc("t5_halt",   E_IDLE, 1'b0, 1'b0, 1'b1);
      cyc("t5_halt_s", E_IDLE, 1'b0, 1'b0, 1'b1);
      rst_i   = 1'b0;
      exp_cnt = '0;
      #1;
      push_exp(E_IDLE, 1'b0, 1'b0, 1'b0);
      pop_cmp("t5_reset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b1; in_s.memacc = 1'b0;
      cyc("t5_idle",  E_IDLE, 1'b0, 1'b0, 1'b0);
      in_s.start = 1'b0;
      cyc("t5_rerun", E_RUN,  1'b0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a MEM_WAIT cycle.
      in_s.memacc = 1'b1;
      cyc("t6_stall", E_MEM, 1'b1, 1'b1, 1'b0);
      push_exp(E_MEM, 1'b1, 1'b1, 1'b0);
      pop_cmp("t6_wait");
      #2;
      rst_i   = 1'b0;
      exp_cnt = '0;
      #1;
      push_exp(E_IDLE, 1'b0, 1'b0, 1'b0);
      pop_cmp("t6_async_rst");
      @(posedge clk_i);
      #1;
      rst_i = 1'b1; in_s.memacc = 1'b0;
      cyc("t6_idle", E_IDLE, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It owns every pipeline-register write enable, flush and bubble control, and the PC write enable. It arbitrates three event sources: load-use hazard, taken branch/jump redirect, and a multi-cycle data-memory handshake with timeout. It replaces ad-hoc per-stage hazard logic, and the datapath instantiates exactly one.

Parameters:
REG_ADDR_W, 5, register-specifier width
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before error (>=2)
CNT_W, 32, width of the stall performance counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  run request, sampled in IDLE
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  REG_ADDR_W  load destination in EX
ifid_rs_i  in  REG_ADDR_W  rs of instruction in ID
ifid_rt_i  in  REG_ADDR_W  rt of instruction in ID
ifid_uses_rt_i  in  1  ID instruction reads rt (R-type, beq, sw)
id_jump_i  in  1  jump decoded in ID
ex_branch_taken_i  in  1  branch resolved taken in EX
exmem_memacc_i  in  1  MEM-stage instruction reads or writes memory
dmem_ack_i  in  1  data memory completes the current access
dmem_req_o  out  1  data-memory access request
pc_write_o  out  1  PC register enable
ifid_write_o  out  1  IF/ID enable
ifid_flush_o  out  1  IF/ID loads NOP
idex_write_o  out  1  ID/EX enable
idex_bubble_o  out  1  ID/EX control fields zeroed
exmem_write_o  out  1  EX/MEM enable
memwb_bubble_o  out  1  MEM/WB RegWrite forced 0
running_o  out  1  state is RUN or MEM_WAIT
err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  saturating count of non-advancing cycles

Behaviour:
- FSM states: IDLE, RUN, MEM_WAIT, HALT.
- Reset is asynchronous: state goes to IDLE, timeout counter to 0, stall_cnt_o to 0, err_o to 0. This applies at any time, including mid-MEM_WAIT.
- IDLE: all enables, flush and bubble outputs are 0; dmem_req_o=0. start_i=1 moves the FSM to RUN on the next edge.
- RUN, default (no event): all write enables are 1; flush and bubble outputs are 0.
- dmem_req_o = exmem_memacc_i in RUN and MEM_WAIT; it is 0 otherwise.
- Memory stall (highest priority) in RUN: exmem_memacc_i=1 and dmem_ack_i=0.
  - This cycle: pc/ifid/idex/exmem write all 0; memwb_bubble_o=1.
  - Next state is MEM_WAIT.
  - An ack in the same cycle means a zero-wait access: no stall.
- MEM_WAIT:
  - Outputs are the same as the memory-stall cycle and dmem_req_o stays 1.
  - On dmem_ack_i=1: that cycle behaves as RUN with all events evaluated, and the next state is RUN.
  - The timeout counter increments each MEM_WAIT cycle without ack. It clears on entering RUN.
  - When the count reaches MEM_TIMEOUT-1 without ack: next state is HALT and err_o is set.
- Branch redirect (second priority) when ex_branch_taken_i=1:
  - pc_write_o=1 (PC takes branch target).
  - ifid_flush_o=1 and idex_bubble_o=1.
  - Load-use and jump are ignored that cycle, because their instructions are squashed.
- Jump (third priority) when id_jump_i=1: pc_write_o=1, ifid_flush_o=1, with no ID/EX bubble.
- Load-use (lowest priority): raised when idex_memread_i=1 and idex_rt_i!=0 and (idex_rt_i==ifid_rs_i or (ifid_uses_rt_i and idex_rt_i==ifid_rt_i)).
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - Lasts exactly one cycle, because the load advances to MEM.
- Jump combined with load-use: load-use wins, and the jump re-presents next cycle.
- HALT: all enables 0; err_o=1 until reset; start_i is ignored.
- stall_cnt_o: increments on every RUN or MEM_WAIT cycle with pc_write_o=0; saturates at all-ones.
- All outputs are combinational from state plus inputs. There is no output register and no added latency.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - state enum (IDLE, RUN, MEM_WAIT, HALT);
  - a packed struct of the stage-control outputs;
  - the opcode constants used to derive ifid_uses_rt_i.
- Optional sub-module `load_use_detect`: combinational compare. The FSM, priority logic and counters stay in the top module.

Test Plan:
1. Reset with start_i=1 held: IDLE for one cycle with all enables 0, then RUN with all enables 1 and running_o=1.
2. lw $2 in EX, add using $2 in ID (rs=2): exactly one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt_o goes from 0 to 1. idex_rt_i=0 produces no stall.
3. ex_branch_taken_i=1 together with a load-use condition: pc_write=1, ifid_flush=1, idex_bubble=1, ifid_write=1; stall_cnt_o unchanged.
4. exmem_memacc_i=1 with ack arriving 3 cycles later: 3 frozen cycles with memwb_bubble=1 and dmem_req=1, advance on the ack cycle; stall_cnt_o +3.
5. MEM_TIMEOUT=4, ack never asserted: HALT reached, err_o=1 and sticky, start_i ignored; rst_i low clears it to IDLE.
6. Assert rst_i low during MEM_WAIT mid-cycle: outputs go to IDLE values immediately, before the next clock edge.
